// File: rtl/ysyx_040750_axi_rd_arbiter_pkg.sv
// Shared types for the AXI read-channel arbiter: FSM state encoding
// and AXI burst-type constants.
package ysyx_040750_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/ysyx_040750_rr_arb2.sv
// Two-way round-robin grant: I_req[1:0] requests, I_prio names the
// favoured requester on a tie, O_grant is one-hot (or zero).
module ysyx_040750_rr_arb2 (
    input  logic [1:0] I_req,
    input  logic       I_prio,
    output logic [1:0] O_grant
);

    always_comb begin
        O_grant = 2'b00;
        unique case (1'b1)
            (I_req == 2'b11): O_grant = I_prio ? 2'b10 : 2'b01;
            (I_req == 2'b01): O_grant = 2'b01;
            (I_req == 2'b10): O_grant = 2'b10;
            default:          O_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_040750_axi_rd_arbiter.sv
// Shares one AXI4 read channel (AR+R) between icache (m0) and dcache (m1).
// Ports: I_clk/I_rst, per-master AR in / R out, memory AR out / R in,
// status O_busy, O_owner, sticky O_len_err.
module ysyx_040750_axi_rd_arbiter
    import ysyx_040750_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,

    input  logic [ADDR_WIDTH-1:0] I_m0_araddr,
    input  logic [LEN_WIDTH-1:0]  I_m0_arlen,
    input  logic [2:0]            I_m0_arsize,
    input  logic [1:0]            I_m0_arburst,
    input  logic                  I_m0_arvalid,
    output logic                  O_m0_arready,
    output logic [DATA_WIDTH-1:0] O_m0_rdata,
    output logic                  O_m0_rvalid,
    output logic                  O_m0_rlast,
    output logic [1:0]            O_m0_rresp,
    input  logic                  I_m0_rready,

    input  logic [ADDR_WIDTH-1:0] I_m1_araddr,
    input  logic [LEN_WIDTH-1:0]  I_m1_arlen,
    input  logic [2:0]            I_m1_arsize,
    input  logic [1:0]            I_m1_arburst,
    input  logic                  I_m1_arvalid,
    output logic                  O_m1_arready,
    output logic [DATA_WIDTH-1:0] O_m1_rdata,
    output logic                  O_m1_rvalid,
    output logic                  O_m1_rlast,
    output logic [1:0]            O_m1_rresp,
    input  logic                  I_m1_rready,

    output logic [ADDR_WIDTH-1:0] O_mem_araddr,
    output logic [LEN_WIDTH-1:0]  O_mem_arlen,
    output logic [2:0]            O_mem_arsize,
    output logic [1:0]            O_mem_arburst,
    output logic                  O_mem_arvalid,
    input  logic                  I_mem_arready,
    input  logic [DATA_WIDTH-1:0] I_mem_rdata,
    input  logic                  I_mem_rvalid,
    input  logic                  I_mem_rlast,
    input  logic [1:0]            I_mem_rresp,
    output logic                  O_mem_rready,

    output logic                  O_busy,
    output logic                  O_owner,
    output logic                  O_len_err
);

    state_t               state_q;
    logic                 owner_q;
    logic                 prio_q;
    logic [LEN_WIDTH-1:0] beat_cnt_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 len_err_q;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       own_arvalid;
    logic       own_rready;
    logic       r_hs;
    logic       live;

    assign req = {I_m1_arvalid, I_m0_arvalid};

    ysyx_040750_rr_arb2 u_arb (
        .I_req   (req),
        .I_prio  (prio_q),
        .O_grant (gnt)
    );

    assign own_arvalid = owner_q ? I_m1_arvalid : I_m0_arvalid;
    assign own_rready  = owner_q ? I_m1_rready  : I_m0_rready;
    assign r_hs = (state_q == ST_DATA) && I_mem_rvalid && own_rready;

    // Reset is synchronous, so state is still stale during the reset
    // cycle; gating keeps every output quiet in that cycle.
    assign live = ~I_rst;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            prio_q     <= 1'b1;
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner_q    <= gnt[1];
                        len_q      <= gnt[1] ? I_m1_arlen : I_m0_arlen;
                        beat_cnt_q <= '0;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!own_arvalid) begin
                        state_q <= ST_IDLE;
                    end else if (I_mem_arready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (I_mem_rlast) begin
                            if (beat_cnt_q != len_q) begin
                                len_err_q <= 1'b1;
                            end
                            prio_q  <= ~owner_q;
                            state_q <= ST_IDLE;
                        end else if (beat_cnt_q == len_q) begin
                            len_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        O_mem_araddr  = '0;
        O_mem_arlen   = '0;
        O_mem_arsize  = '0;
        O_mem_arburst = '0;
        O_mem_arvalid = 1'b0;
        O_mem_rready  = 1'b0;
        O_m0_arready  = 1'b0;
        O_m1_arready  = 1'b0;
        O_m0_rdata    = '0;
        O_m0_rvalid   = 1'b0;
        O_m0_rlast    = 1'b0;
        O_m0_rresp    = '0;
        O_m1_rdata    = '0;
        O_m1_rvalid   = 1'b0;
        O_m1_rlast    = 1'b0;
        O_m1_rresp    = '0;
        if (live && state_q == ST_ADDR) begin
            O_mem_araddr  = owner_q ? I_m1_araddr  : I_m0_araddr;
            O_mem_arlen   = owner_q ? I_m1_arlen   : I_m0_arlen;
            O_mem_arsize  = owner_q ? I_m1_arsize  : I_m0_arsize;
            O_mem_arburst = owner_q ? I_m1_arburst : I_m0_arburst;
            O_mem_arvalid = own_arvalid;
            O_m0_arready  = ~owner_q & I_mem_arready;
            O_m1_arready  = owner_q & I_mem_arready;
        end
        if (live && state_q == ST_DATA) begin
            O_mem_rready = own_rready;
            if (owner_q) begin
                O_m1_rdata  = I_mem_rdata;
                O_m1_rvalid = I_mem_rvalid;
                O_m1_rlast  = I_mem_rlast;
                O_m1_rresp  = I_mem_rresp;
            end else begin
                O_m0_rdata  = I_mem_rdata;
                O_m0_rvalid = I_mem_rvalid;
                O_m0_rlast  = I_mem_rlast;
                O_m0_rresp  = I_mem_rresp;
            end
        end
    end

    assign O_busy    = live && (state_q != ST_IDLE);
    assign O_owner   = live && owner_q;
    assign O_len_err = live && len_err_q;

endmodule

// File: tb/tb_ysyx_040750_axi_rd_arbiter.sv
// Self-checking bench for the AXI read arbiter: directed scenarios
// plus randomized bursts against a transaction-level model.
module tb_ysyx_040750_axi_rd_arbiter;
    import ysyx_040750_axi_rd_arbiter_pkg::*;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [31:0] I_m0_araddr, I_m1_araddr;
    logic [7:0]  I_m0_arlen, I_m1_arlen;
    logic [2:0]  I_m0_arsize, I_m1_arsize;
    logic [1:0]  I_m0_arburst, I_m1_arburst;
    logic        I_m0_arvalid, I_m1_arvalid;
    logic        O_m0_arready, O_m1_arready;
    logic [63:0] O_m0_rdata, O_m1_rdata;
    logic        O_m0_rvalid, O_m1_rvalid;
    logic        O_m0_rlast, O_m1_rlast;
    logic [1:0]  O_m0_rresp, O_m1_rresp;
    logic        I_m0_rready, I_m1_rready;
    logic [31:0] O_mem_araddr;
    logic [7:0]  O_mem_arlen;
    logic [2:0]  O_mem_arsize;
    logic [1:0]  O_mem_arburst;
    logic        O_mem_arvalid, I_mem_arready;
    logic [63:0] I_mem_rdata;
    logic        I_mem_rvalid, I_mem_rlast;
    logic [1:0]  I_mem_rresp;
    logic        O_mem_rready, O_busy, O_owner, O_len_err;

    int nvec = 0;
    int nerr = 0;
    bit m_prio;
    bit m_err;

    logic any_out;

    always #5 I_clk = ~I_clk;

    ysyx_040750_axi_rd_arbiter dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_m0_araddr(I_m0_araddr), .I_m0_arlen(I_m0_arlen),
        .I_m0_arsize(I_m0_arsize), .I_m0_arburst(I_m0_arburst),
        .I_m0_arvalid(I_m0_arvalid), .O_m0_arready(O_m0_arready),
        .O_m0_rdata(O_m0_rdata), .O_m0_rvalid(O_m0_rvalid),
        .O_m0_rlast(O_m0_rlast), .O_m0_rresp(O_m0_rresp),
        .I_m0_rready(I_m0_rready),
        .I_m1_araddr(I_m1_araddr), .I_m1_arlen(I_m1_arlen),
        .I_m1_arsize(I_m1_arsize), .I_m1_arburst(I_m1_arburst),
        .I_m1_arvalid(I_m1_arvalid), .O_m1_arready(O_m1_arready),
        .O_m1_rdata(O_m1_rdata), .O_m1_rvalid(O_m1_rvalid),
        .O_m1_rlast(O_m1_rlast), .O_m1_rresp(O_m1_rresp),
        .I_m1_rready(I_m1_rready),
        .O_mem_araddr(O_mem_araddr), .O_mem_arlen(O_mem_arlen),
        .O_mem_arsize(O_mem_arsize), .O_mem_arburst(O_mem_arburst),
        .O_mem_arvalid(O_mem_arvalid), .I_mem_arready(I_mem_arready),
        .I_mem_rdata(I_mem_rdata), .I_mem_rvalid(I_mem_rvalid),
        .I_mem_rlast(I_mem_rlast), .I_mem_rresp(I_mem_rresp),
        .O_mem_rready(O_mem_rready),
        .O_busy(O_busy), .O_owner(O_owner), .O_len_err(O_len_err)
    );

    assign any_out = |{O_m0_arready, O_m1_arready, O_m0_rdata, O_m1_rdata,
                       O_m0_rvalid, O_m1_rvalid, O_m0_rlast, O_m1_rlast,
                       O_m0_rresp, O_m1_rresp, O_mem_araddr, O_mem_arlen,
                       O_mem_arsize, O_mem_arburst, O_mem_arvalid,
                       O_mem_rready, O_busy, O_owner, O_len_err};

    // One full transaction: request(s) in the idle cycle, AR phase with
    // `stall` cycles of arready low, then `nbeats` R beats (rlast on the
    // last) with an owner rready gap of `gap` cycles at beat `gap_at`.
    task automatic do_burst(input bit r0, input bit r1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [7:0] l0, input logic [7:0] l1,
                            input logic [2:0] sz, input logic [1:0] bt,
                            input int stall, input int nbeats,
                            input int gap_at, input int gap,
                            input bit rnd_valid);
        bit          w;
        bit          rdy;
        bit          done;
        int          b;
        int          gcnt;
        logic [7:0]  len;
        logic [31:0] addr;
        logic        ov;
        logic        ol;
        logic [63:0] od;
        logic [1:0]  orr;
        w    = (r0 && r1) ? m_prio : r1;
        len  = w ? l1 : l0;
        addr = w ? a1 : a0;
        I_m0_araddr  = a0;
        I_m1_araddr  = a1;
        I_m0_arlen   = l0;
        I_m1_arlen   = l1;
        I_m0_arsize  = w ? ~sz : sz;
        I_m1_arsize  = w ? sz : ~sz;
        I_m0_arburst = w ? ~bt : bt;
        I_m1_arburst = w ? bt : ~bt;
        I_m0_arvalid = r0;
        I_m1_arvalid = r1;
        I_mem_arready = 1'b0;
        I_mem_rvalid  = 1'b0;
        @(negedge I_clk);
        nvec++;
        if ({O_busy, O_m0_arready, O_m1_arready, O_mem_arvalid} !== 4'b0) begin
            nerr++;
            $display("FAIL idle_quiet: got %b want 0000",
                     {O_busy, O_m0_arready, O_m1_arready, O_mem_arvalid});
        end
        nvec++;
        if (O_len_err !== m_err) begin
            nerr++;
            $display("FAIL idle_len_err: got %b want %b", O_len_err, m_err);
        end
        @(posedge I_clk); #1;
        for (int c = 0; c <= stall; c++) begin
            I_mem_arready = (c == stall);
            @(negedge I_clk);
            nvec++;
            if ({O_busy, O_owner, O_mem_arvalid} !== {1'b1, w, 1'b1}) begin
                nerr++;
                $display("FAIL addr_grant: busy/owner/arvalid got %b want %b",
                         {O_busy, O_owner, O_mem_arvalid}, {1'b1, w, 1'b1});
            end
            nvec++;
            if ({O_mem_araddr, O_mem_arlen, O_mem_arsize, O_mem_arburst}
                !== {addr, len, sz, bt}) begin
                nerr++;
                $display("FAIL addr_fields: got %h/%h/%b/%b want %h/%h/%b/%b",
                         O_mem_araddr, O_mem_arlen, O_mem_arsize, O_mem_arburst,
                         addr, len, sz, bt);
            end
            nvec++;
            if ((w ? {O_m1_arready, O_m0_arready} : {O_m0_arready, O_m1_arready})
                !== {(c == stall), 1'b0}) begin
                nerr++;
                $display("FAIL addr_arready: m0 %b m1 %b want owner=%b other=0",
                         O_m0_arready, O_m1_arready, (c == stall));
            end
            @(posedge I_clk); #1;
        end
        I_mem_arready = 1'b0;
        if (w) I_m1_arvalid = 1'b0;
        else   I_m0_arvalid = 1'b0;
        b = 0;
        gcnt = 0;
        done = 1'b0;
        while (!done) begin
            I_mem_rvalid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            I_mem_rdata  = {$urandom, $urandom};
            I_mem_rresp  = 2'($urandom);
            I_mem_rlast  = (b == nbeats - 1);
            rdy = 1'b1;
            if (b == gap_at && gcnt < gap) begin
                rdy = 1'b0;
                gcnt++;
            end
            if (w) begin
                I_m1_rready = rdy;
                I_m0_rready = 1'($urandom);
            end else begin
                I_m0_rready = rdy;
                I_m1_rready = 1'($urandom);
            end
            @(negedge I_clk);
            ov  = w ? O_m1_rvalid : O_m0_rvalid;
            ol  = w ? O_m1_rlast  : O_m0_rlast;
            od  = w ? O_m1_rdata  : O_m0_rdata;
            orr = w ? O_m1_rresp  : O_m0_rresp;
            nvec++;
            if ({ov, ol, od, orr} !== {I_mem_rvalid, I_mem_rlast, I_mem_rdata,
                                       I_mem_rresp}) begin
                nerr++;
                $display("FAIL data_owner: got v%b l%b %h r%b want v%b l%b %h r%b",
                         ov, ol, od, orr, I_mem_rvalid, I_mem_rlast,
                         I_mem_rdata, I_mem_rresp);
            end
            nvec++;
            if ((w ? |{O_m0_rvalid, O_m0_rlast, O_m0_rdata, O_m0_rresp}
                   : |{O_m1_rvalid, O_m1_rlast, O_m1_rdata, O_m1_rresp}) !== 1'b0) begin
                nerr++;
                $display("FAIL data_other: non-owner R outputs nonzero, want 0");
            end
            nvec++;
            if ({O_mem_rready, O_mem_arvalid, O_busy} !== {rdy, 1'b0, 1'b1}) begin
                nerr++;
                $display("FAIL data_ctrl: rready/arvalid/busy got %b want %b",
                         {O_mem_rready, O_mem_arvalid, O_busy}, {rdy, 1'b0, 1'b1});
            end
            nvec++;
            if (O_len_err !== m_err) begin
                nerr++;
                $display("FAIL data_len_err: got %b want %b", O_len_err, m_err);
            end
            if (I_mem_rvalid && rdy) begin
                if (I_mem_rlast && b[7:0] != len) m_err = 1'b1;
                if (!I_mem_rlast && b[7:0] == len) m_err = 1'b1;
                if (I_mem_rlast) done = 1'b1;
                b++;
            end
            @(posedge I_clk); #1;
        end
        I_mem_rvalid = 1'b0;
        I_mem_rlast  = 1'b0;
        I_m0_arvalid = 1'b0;
        I_m1_arvalid = 1'b0;
        m_prio = ~w;
    endtask

    task automatic apply_reset();
        I_rst = 1'b1;
        @(negedge I_clk);
        nvec++;
        if (any_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_cycle_outputs: got %b want 0", any_out);
        end
        @(posedge I_clk); #1;
        I_rst = 1'b0;
        I_mem_rvalid = 1'b0;
        m_prio = 1'b1;
        m_err  = 1'b0;
        @(negedge I_clk);
        nvec++;
        if (any_out !== 1'b0) begin
            nerr++;
            $display("FAIL post_reset_outputs: got %b want 0", any_out);
        end
        @(posedge I_clk); #1;
    endtask

    task automatic test_reset();
        I_m0_arvalid = 1'b1;
        I_m1_arvalid = 1'b1;
        I_mem_rvalid = 1'b1;
        I_mem_arready = 1'b1;
        I_rst = 1'b1;
        @(negedge I_clk);
        nvec++;
        if (any_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_active: got %b want 0", any_out);
        end
        I_m0_arvalid = 1'b0;
        I_m1_arvalid = 1'b0;
        I_mem_arready = 1'b0;
        @(posedge I_clk); #1;
        apply_reset();
    endtask

    task automatic test_single();
        do_burst(1, 0, 32'h8000_0000, 32'h0, 8'd3, 8'd0, 3'b011, BURST_INCR,
                 0, 4, -1, 0, 0);
    endtask

    task automatic test_both();
        do_burst(1, 1, 32'h8000_1000, 32'h8000_2000, 8'd1, 8'd2, 3'b011,
                 BURST_INCR, 0, 3, -1, 0, 0);
        do_burst(1, 1, 32'h8000_1040, 32'h8000_2040, 8'd3, 8'd1, 3'b011,
                 BURST_INCR, 1, 4, -1, 0, 0);
        do_burst(1, 1, 32'h8000_1080, 32'h8000_2080, 8'd0, 8'd1, 3'b011,
                 BURST_INCR, 0, 2, -1, 0, 0);
    endtask

    task automatic test_mmio();
        do_burst(0, 1, 32'h0, 32'ha000_03f8, 8'd0, 8'd0, 3'b010, BURST_FIXED,
                 0, 1, -1, 0, 0);
    endtask

    task automatic test_stall();
        do_burst(1, 0, 32'h8000_3000, 32'h0, 8'd3, 8'd0, 3'b011, BURST_INCR,
                 5, 4, 1, 2, 0);
    endtask

    task automatic test_len_err();
        do_burst(1, 0, 32'h8000_4000, 32'h0, 8'd3, 8'd0, 3'b011, BURST_INCR,
                 0, 3, -1, 0, 0);
        do_burst(0, 1, 32'h0, 32'h8000_5000, 8'd0, 8'd1, 3'b011, BURST_INCR,
                 0, 2, -1, 0, 0);
        apply_reset();
        nvec++;
        if (O_len_err !== 1'b0) begin
            nerr++;
            $display("FAIL len_err_cleared: got %b want 0", O_len_err);
        end
    endtask

    task automatic test_reset_mid();
        I_m0_araddr  = 32'h8000_6000;
        I_m0_arlen   = 8'd3;
        I_m0_arvalid = 1'b1;
        @(posedge I_clk); #1;
        I_mem_arready = 1'b1;
        @(posedge I_clk); #1;
        I_mem_arready = 1'b0;
        I_m0_arvalid  = 1'b0;
        I_m0_rready   = 1'b1;
        I_mem_rvalid  = 1'b1;
        I_mem_rlast   = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        nvec++;
        if ({O_busy, O_m0_rvalid} !== 2'b11) begin
            nerr++;
            $display("FAIL mid_burst_active: got %b want 11", {O_busy, O_m0_rvalid});
        end
        apply_reset();
        do_burst(1, 1, 32'h8000_7000, 32'h8000_8000, 8'd1, 8'd1, 3'b011,
                 BURST_INCR, 0, 2, -1, 0, 0);
    endtask

    task automatic test_addr_abort();
        I_m0_araddr  = 32'h8000_9000;
        I_m0_arlen   = 8'd1;
        I_m0_arvalid = 1'b1;
        @(posedge I_clk); #1;
        @(negedge I_clk);
        nvec++;
        if ({O_busy, O_mem_arvalid} !== 2'b11) begin
            nerr++;
            $display("FAIL abort_addr: got %b want 11", {O_busy, O_mem_arvalid});
        end
        @(posedge I_clk); #1;
        I_m0_arvalid = 1'b0;
        @(posedge I_clk); #1;
        @(negedge I_clk);
        nvec++;
        if ({O_busy, O_len_err} !== {1'b0, m_err}) begin
            nerr++;
            $display("FAIL abort_idle: got %b want %b", {O_busy, O_len_err},
                     {1'b0, m_err});
        end
        @(posedge I_clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int          rq;
            int          ln0;
            int          ln1;
            int          nb;
            int          ln;
            bit          w;
            rq  = $urandom_range(1, 3);
            ln0 = $urandom_range(0, 7);
            ln1 = $urandom_range(0, 7);
            w   = (rq == 3) ? m_prio : (rq == 2);
            ln  = w ? ln1 : ln0;
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : ln + 1;
            do_burst(rq[0], rq[1], $urandom, $urandom, 8'(ln0), 8'(ln1),
                     3'($urandom), 2'($urandom), $urandom_range(0, 3), nb,
                     $urandom_range(0, 3), $urandom_range(0, 2), 1);
        end
    endtask

    initial begin
        I_rst = 1'b1;
        I_m0_araddr = '0;  I_m1_araddr = '0;
        I_m0_arlen = '0;   I_m1_arlen = '0;
        I_m0_arsize = '0;  I_m1_arsize = '0;
        I_m0_arburst = '0; I_m1_arburst = '0;
        I_m0_arvalid = 0;  I_m1_arvalid = 0;
        I_m0_rready = 0;   I_m1_rready = 0;
        I_mem_arready = 0; I_mem_rdata = '0;
        I_mem_rvalid = 0;  I_mem_rlast = 0;
        I_mem_rresp = '0;
        m_prio = 1'b1;
        m_err  = 1'b0;
        repeat (2) @(posedge I_clk);
        #1;
        test_reset();
        test_single();
        test_both();
        test_mmio();
        test_stall();
        test_len_err();
        test_reset_mid();
        test_addr_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_axi_rd_arbiter.md
Name: ysyx_040750_axi_rd_arbiter

Overview:
- Shares the single AXI4 read channel (AR + R) to memory between the icache controller (master 0) and the dcache controller (master 1).
- Grants one master per transaction and locks the grant until the last R beat. Steers R beats only to the owner and back-pressures the other master's AR.
- Checks burst length against arlen and flags protocol errors.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 64, R data width.
- LEN_WIDTH, 8, arlen width; beat counter width.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  reset; synchronous, active-high.
- I_m0_araddr / I_m1_araddr  in  ADDR_WIDTH  master AR address.
- I_m0_arlen / I_m1_arlen  in  8  burst length minus 1.
- I_m0_arsize / I_m1_arsize  in  3  beat size.
- I_m0_arburst / I_m1_arburst  in  2  burst type.
- I_m0_arvalid / I_m1_arvalid  in  1  AR valid.
- O_m0_arready / O_m1_arready  out  1  AR ready to master.
- O_m0_rdata / O_m1_rdata  out  DATA_WIDTH  R data to master.
- O_m0_rvalid / O_m1_rvalid  out  1  R valid to master.
- O_m0_rlast / O_m1_rlast  out  1  R last to master.
- O_m0_rresp / O_m1_rresp  out  2  R response to master.
- I_m0_rready / I_m1_rready  in  1  master R ready.
- O_mem_araddr  out  ADDR_WIDTH  to memory.
- O_mem_arlen  out  8  to memory.
- O_mem_arsize  out  3  to memory.
- O_mem_arburst  out  2  to memory.
- O_mem_arvalid  out  1  to memory.
- I_mem_arready  in  1  from memory.
- I_mem_rdata  in  DATA_WIDTH  from memory.
- I_mem_rvalid  in  1  from memory.
- I_mem_rlast  in  1  from memory.
- I_mem_rresp  in  2  from memory.
- O_mem_rready  out  1  to memory.
- O_busy  out  1  transaction in flight (state != IDLE).
- O_owner  out  1  current/last grant: 0 = icache, 1 = dcache.
- O_len_err  out  1  sticky: rlast position disagreed with latched arlen.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset: state = IDLE, owner = 0, prio = 1 (dcache favoured first), beat_cnt = 0, len_err = 0.
- Reset value of every output is 0: all arvalid/arready/rvalid/rlast/rready outputs, all data/addr/len/size/burst/resp outputs, O_busy, O_owner, O_len_err.
- Reset mid-burst: return to IDLE immediately; in-flight beats are dropped; no outputs asserted in the reset cycle.
- IDLE:
  - No AR forwarded; O_mX_arready = 0.
  - Arbitration: if only one arvalid, grant it. If both, grant the prio master.
  - On grant: owner <= granted, latch its arlen into len_q, beat_cnt <= 0, go to ADDR. One cycle grant latency.
- ADDR:
  - O_mem_ar* = owner master's AR fields, combinationally.
  - O_mem_arvalid = owner arvalid; O_m{owner}_arready = I_mem_arready; the other master's arready = 0.
  - On AR handshake go to DATA.
  - If owner drops arvalid before handshake (protocol violation), return to IDLE; len_err unchanged.
- DATA:
  - O_mem_arvalid = 0.
  - O_m{owner}_rdata/rresp/rlast = mem values; O_m{owner}_rvalid = I_mem_rvalid; O_mem_rready = I_m{owner}_rready.
  - Non-owner rvalid = 0; its data/resp/rlast outputs are driven 0.
  - Each R handshake: beat_cnt += 1, wrapping at 2^LEN_WIDTH.
  - On the handshake with I_mem_rlast: if beat_cnt != len_q, set len_err. Then prio <= ~owner and go to IDLE.
  - A handshake with beat_cnt == len_q and no rlast also sets len_err; transfer continues until rlast.
- Back-to-back: a new grant can occur in the IDLE cycle following rlast. Minimum gap between bursts is 1 idle cycle plus the ADDR cycle.
- Round-robin prio updates only on a completed burst, so neither master starves.
- A single requester is granted regardless of prio.
- O_len_err clears only on reset.
- No combinational path from I_mem_arready to O_mem_arvalid.

Decomposition:
- Shared package/header: FSM state encodings (IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10) and AXI burst constants (FIXED = 2'b00, INCR = 2'b01).
- Natural sub-module: ysyx_040750_rr_arb2, the 2-way round-robin grant logic (req[1:0], prio, grant one-hot), reusable for the write-channel arbiter.
- Muxing and the FSM stay in the top module.

Test Plan:
1. Reset, then m0 arvalid, araddr=0x80000000, arlen=3, memory gives 4 beats with rlast on the 4th. Expect grant latency 1 cycle, O_mem_araddr=0x80000000, 4 beats delivered only to m0, m1 rvalid stays 0, O_len_err=0, then IDLE.
2. m0 and m1 assert arvalid in the same cycle after reset. Expect m1 (dcache) granted first. After its rlast, m0 granted next. After m0 completes with both re-requesting, m1 granted (alternation).
3. m1 MMIO read, arlen=0, arsize=3'b010, arburst=2'b00, a single beat with rlast. Expect fields passed through unchanged and the transaction completes in DATA with one beat.
4. Memory stalls arready for 5 cycles, then m0 deasserts rready for 2 cycles mid-burst. Expect arvalid held, O_mem_rready low for exactly those 2 cycles, beat count unaffected.
5. arlen=3 but memory asserts rlast on beat 2. Expect O_len_err=1, sticky through the next correct burst, cleared by I_rst.
6. Assert I_rst during DATA beat 2. Expect all outputs 0 in the cycle after reset and a fresh grant to the prio master (m1) on the next request.
